// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan address sequencer and its helpers.
package scan_seq_pkg;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_ADDR = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

endpackage

// File: rtl/mask_next_finder.sv
// Combinational search over an address-enable mask: next enabled index strictly above
// the current one, plus the lowest enabled index overall.
module mask_next_finder
    import scan_seq_pkg::*;
(
    input  logic [NUM_ADDR-1:0] mask,
    input  logic [ADDR_W-1:0]   cur,
    output logic [ADDR_W-1:0]   next_above,
    output logic                found,
    output logic [ADDR_W-1:0]   lowest,
    output logic                any
);

    // Descending scans, so the last hit written is the lowest qualifying index.
    always_comb begin
        next_above = '0;
        found      = 1'b0;
        lowest     = '0;
        any        = 1'b0;
        for (int i = int'(NUM_ADDR) - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                next_above = ADDR_W'(i);
                found      = 1'b1;
            end
            if (mask[i]) begin
                lowest = ADDR_W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_addr_sequencer.sv
// Steps a registered 3-bit decoder select code through the enabled addresses of a mask,
// holding each for dwell+1 cycles, in single-sweep or continuous mode.
module scan_addr_sequencer #(
    parameter int unsigned DWELL_W  = 8,
    parameter int unsigned NUM_ADDR = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                cont,
    input  logic [NUM_ADDR-1:0] mask,
    input  logic [DWELL_W-1:0]  dwell,
    output logic                a,
    output logic                b,
    output logic                c,
    output logic                valid,
    output logic                busy,
    output logic                done,
    output logic                wrap
);

    import scan_seq_pkg::ADDR_W;
    import scan_seq_pkg::state_e;
    import scan_seq_pkg::IDLE;
    import scan_seq_pkg::SCAN;
    import scan_seq_pkg::DONE;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [NUM_ADDR-1:0] mask_q, mask_d;
    logic                cont_q, cont_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wrap_q, wrap_d;

    logic [NUM_ADDR-1:0] find_mask;
    logic [ADDR_W-1:0]   next_above, lowest;
    logic                found, any;

    // In IDLE the mask being latched this edge is the live input, so search it directly.
    assign find_mask = (state_q == IDLE) ? mask : mask_q;

    mask_next_finder u_finder (
        .mask       (find_mask),
        .cur        (addr_q),
        .next_above (next_above),
        .found      (found),
        .lowest     (lowest),
        .any        (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = any ? SCAN : DONE;
            SCAN:    if ((cnt_q == '0) && !found && !cont_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (stop) state_d = IDLE;
    end

    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mask_d  = mask;
                    dwell_d = dwell;
                    cont_d  = cont;
                    if (any) begin
                        addr_d  = lowest;
                        cnt_d   = dwell;
                        valid_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (found) begin
                    addr_d = next_above;
                    cnt_d  = dwell_q;
                end else if (cont_q) begin
                    addr_d = lowest;
                    cnt_d  = dwell_q;
                    wrap_d = 1'b1;
                end else begin
                    addr_d  = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                addr_d  = '0;
                valid_d = 1'b0;
            end
        endcase
        if (stop) begin
            addr_d  = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            wrap_d  = 1'b0;
        end
        busy_d = (state_d == SCAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign a     = addr_q[2];
    assign b     = addr_q[1];
    assign c     = addr_q[0];
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_addr_sequencer.sv
// Directed bench for scan_addr_sequencer; observed vector is {a,b,c,valid,busy,done,wrap}.
module tb_scan_addr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [7:0] dwell = 8'h00;
    logic       a, b, c, valid, busy, done, wrap;
    logic [6:0] obs;
    logic [6:0] exp;

    int checks = 0;
    int errors = 0;

    assign obs = {a, b, c, valid, busy, done, wrap};

    always #5 clk = ~clk;

    scan_addr_sequencer #(
        .DWELL_W  (8),
        .NUM_ADDR (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .mask  (mask),
        .dwell (dwell),
        .a     (a),
        .b     (b),
        .c     (c),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    task automatic kick(input logic [7:0] m, input logic [7:0] d, input logic cn);
        @(negedge clk);
        mask  = m;
        dwell = d;
        cont  = cn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", obs, 7'b0);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", obs, 7'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs, 7'b0);
        end
    endtask

    task automatic test_single_sweep();
        logic [2:0] codes [8] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
        kick(8'b1010_0101, 8'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp = {codes[i], 4'b1100};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL sweep_code cycle %0d: got %b expected %b", i, obs, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== 7'b000_0010) begin
            errors++;
            $display("FAIL sweep_done: got %b expected %b", obs, 7'b000_0010);
        end
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL sweep_after: got %b expected %b", obs, 7'b0);
        end
    endtask

    task automatic test_continuous();
        kick(8'hFF, 8'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            exp = {3'(i % 8), 3'b110, (i == 8)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL cont_code cycle %0d: got %b expected %b", i, obs, exp);
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL cont_stop: got %b expected %b", obs, 7'b0);
        end
    endtask

    task automatic test_empty_mask();
        kick(8'h00, 8'd5, 1'b0);
        checks++;
        if (obs !== 7'b000_0010) begin
            errors++;
            $display("FAIL empty_done: got %b expected %b", obs, 7'b000_0010);
        end
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL empty_after: got %b expected %b", obs, 7'b0);
        end
    endtask

    task automatic test_single_bit_wrap();
        kick(8'h10, 8'd3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            exp = {3'd4, 3'b110, (i == 4 || i == 8)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_bit cycle %0d: got %b expected %b", i, obs, exp);
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_stop();
        kick(8'hFF, 8'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp = {3'(i / 3), 4'b1100};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stop_pre cycle %0d: got %b expected %b", i, obs, exp);
            end
            if (i < 9) @(negedge clk);
        end
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL stop_idle: got %b expected %b", obs, 7'b0);
        end
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL stop_no_restart: got %b expected %b", obs, 7'b0);
        end
    endtask

    task automatic test_async_reset();
        kick(8'h0C, 8'd1, 1'b1);
        checks++;
        if (obs !== 7'b010_1100) begin
            errors++;
            $display("FAIL arst_pre: got %b expected %b", obs, 7'b010_1100);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL arst_immediate: got %b expected %b", obs, 7'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        kick(8'h0C, 8'd1, 1'b0);
        checks++;
        if (obs !== 7'b010_1100) begin
            errors++;
            $display("FAIL arst_restart: got %b expected %b", obs, 7'b010_1100);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 7'b011_1100) begin
            errors++;
            $display("FAIL arst_next: got %b expected %b", obs, 7'b011_1100);
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_continuous();
        test_empty_mask();
        test_single_bit_wrap();
        test_stop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_addr_sequencer.md
Name: scan_addr_sequencer

Overview:
Upstream stage for the 3:8 decoder. It generates the 3-bit select code {a,b,c} that drives the decoder inputs. The code steps through the enabled addresses of an 8-bit mask, holding each one for a programmable dwell time, in single-sweep or continuous mode. Outputs are registered so the decoder sees glitch-free codes.

Parameters:
DWELL_W, 8, width of the dwell count input.
NUM_ADDR, 8, number of decoder outputs (fixed 2**3); drives the mask width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin a scan; sampled in IDLE only.
stop  input  1  abort the scan; highest priority.
cont  input  1  1 = continuous wrap, 0 = single sweep; latched on start.
mask  input  NUM_ADDR  per-address enable, bit i = code i; latched on start.
dwell  input  DWELL_W  each address is held dwell+1 cycles; latched on start.
a  output  1  select MSB (code bit 2).
b  output  1  select bit 1.
c  output  1  select LSB (code bit 0).
valid  output  1  {a,b,c} is a live address that the decoder output should honour.
busy  output  1  high in SCAN.
done  output  1  one-cycle pulse when a single sweep completes.
wrap  output  1  one-cycle pulse when a continuous scan wraps to its first address.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE; a=b=c=0; valid=0; busy=0; done=0; wrap=0; latched registers=0.
- Reset asserted mid-scan: same values take effect immediately, without waiting for a clock edge.
- State machine: IDLE, SCAN, DONE.
- IDLE with start=1 and stop=0 at edge k:
  - Latch mask, dwell and cont.
  - If the latched mask is 0: go to DONE. done pulses in cycle k+1. valid stays 0.
  - Otherwise: {a,b,c} = lowest set index; valid=1; busy=1; dwell counter = dwell; go to SCAN. Outputs are visible in cycle k+1 (1-cycle latency).
- SCAN, dwell counter != 0: decrement; the address holds.
- SCAN, counter == 0 at an edge: search for the next set mask bit strictly above the current index.
  - Bit found: load that index and reload the counter.
  - No bit found, cont=1: load the lowest set index, reload the counter, pulse wrap for 1 cycle. valid stays 1 with no gap.
  - No bit found, cont=0: go to DONE; valid=0, busy=0, a=b=c=0, done=1 for 1 cycle.
- Single-bit mask with cont=1: the address never changes, and wrap pulses every dwell+1 cycles.
- DONE: unconditionally return to IDLE on the next edge. start is ignored in DONE.
- stop=1 in any state: go to IDLE next edge with valid=0, busy=0, a=b=c=0, and no done or wrap pulse. stop beats a simultaneous start.
- start while in SCAN is ignored. Changes to mask, dwell or cont during SCAN have no effect until the next start.
- Per-address hold time is dwell+1 cycles (dwell=0 gives a new address every cycle). The counter is DWELL_W bits and never underflows.
- Address arithmetic is 3-bit unsigned. The wrap from 7 to the lowest set bit is handled only by the search, never by overflow.

Decomposition:
- Package scan_seq_pkg:
  - state enum {IDLE, SCAN, DONE};
  - ADDR_W=3;
  - NUM_ADDR=8.
- Sub-module mask_next_finder (combinational):
  - inputs: mask, current index;
  - outputs: next_above index + found flag, and lowest index + any flag.
  - Used for both the initial load and each advance.

Test Plan:
- mask=8'b1010_0101, dwell=1, cont=0, start pulse → {a,b,c} = 0,0,2,2,5,5,7,7 with valid=1 for 8 cycles, then done=1 for exactly 1 cycle, then valid=0 and busy=0.
- mask=8'hFF, dwell=0, cont=1 → codes 0..7 once per cycle, then 0 again with wrap=1 in the cycle code 0 reappears; valid never drops.
- mask=8'h00, start → done pulses in the cycle after start; valid is never asserted.
- mask=8'h10, dwell=3, cont=1 → {a,b,c}=4 constant; wrap pulses every 4 cycles.
- Mid-scan stop (mask=8'hFF, dwell=2, stop asserted while code=3) → next cycle valid=0, a=b=c=0, no done. A start in the same cycle as stop is ignored.
- Asynchronous rst asserted between clock edges during SCAN → all outputs 0 before the next edge. After release, a start restarts from the lowest set index.
